// File: rtl/muntjac_csr_access_ctrl_if.sv
// Request / CSR-storage / response signal bundle for muntjac_csr_access_ctrl.
// Signal suffixes are from the controller's point of view.
interface muntjac_csr_access_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      req_op_i;
  logic [11:0]     req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic [1:0]      req_priv_i;
  logic [11:0]     csr_addr_o;
  logic            csr_re_o;
  logic [XLEN-1:0] csr_rdata_i;
  logic            csr_we_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_rdata_o;
  logic            resp_illegal_o;

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_priv_i,
    input  csr_rdata_i, resp_ready_i,
    output req_ready_o, csr_addr_o, csr_re_o, csr_we_o, csr_wdata_o,
    output resp_valid_o, resp_rdata_o, resp_illegal_o
  );

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_priv_i,
    output csr_rdata_i, resp_ready_i,
    input  req_ready_o, csr_addr_o, csr_re_o, csr_we_o, csr_wdata_o,
    input  resp_valid_o, resp_rdata_o, resp_illegal_o
  );
endinterface

// File: rtl/muntjac_csr_access_ctrl.sv
// CSR access sequencer: legality check, read, optional read-modify-write, response.
// Optional feature macro: MUNTJAC_CSR_PRIV_CHECK_EN (privilege-level fault check).
module muntjac_csr_access_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input logic clk_i,
  input logic rst_i,
  muntjac_csr_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SET, OP_CLEAR} csr_op_e;

  state_e          state_q, state_d;
  csr_op_e         op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            ready_q, ready_d;
  logic            re_q, re_d;
  logic            we_q, we_d;
  logic [11:0]     caddr_q, caddr_d;
  logic [XLEN-1:0] cwdata_q, cwdata_d;
  logic            rvalid_q, rvalid_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            illegal_q, illegal_d;

  logic            priv_fault_c;
  logic            in_intent_c, in_illegal_c, lat_intent_c, fire_c;
  logic [XLEN-1:0] merged_c;

`ifdef MUNTJAC_CSR_PRIV_CHECK_EN
  assign priv_fault_c = bus.req_priv_i < bus.req_addr_i[9:8];
`else
  assign priv_fault_c = 1'b0;
`endif

  // SET/CLEAR with a zero operand cannot change anything, so it is a pure read
  assign in_intent_c  = (csr_op_e'(bus.req_op_i) == OP_WRITE) ||
                        ((csr_op_e'(bus.req_op_i) inside {OP_SET, OP_CLEAR}) &&
                         (bus.req_wdata_i != '0));
  assign in_illegal_c = (in_intent_c && (bus.req_addr_i[11:10] == 2'b11)) || priv_fault_c;
  assign lat_intent_c = (op_q == OP_WRITE) ||
                        ((op_q inside {OP_SET, OP_CLEAR}) && (wdata_q != '0));
  assign fire_c       = bus.req_valid_i && ready_q;

  always_comb begin
    case (op_q)
      OP_SET:   merged_c = bus.csr_rdata_i | wdata_q;
      OP_CLEAR: merged_c = bus.csr_rdata_i & ~wdata_q;
      default:  merged_c = wdata_q;
    endcase
  end

  // Next state, latched request fields and next registered outputs
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    cwdata_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (fire_c) begin
          op_d    = csr_op_e'(bus.req_op_i);
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          if (in_illegal_c) begin
            state_d   = ST_RESP;
            rdata_d   = '0;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        rdata_d   = bus.csr_rdata_i;
        illegal_d = 1'b0;
        if (lat_intent_c) begin
          state_d  = ST_WRITE;
          cwdata_d = merged_c;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready_i) begin
          state_d   = ST_IDLE;
          rdata_d   = '0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d  = (state_d == ST_IDLE);
    re_d     = (state_d == ST_READ);
    we_d     = (state_d == ST_WRITE);
    rvalid_d = (state_d == ST_RESP);
    caddr_d  = (state_d inside {ST_READ, ST_WRITE}) ? addr_d : 12'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b1;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      caddr_q   <= '0;
      cwdata_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      re_q      <= re_d;
      we_q      <= we_d;
      caddr_q   <= caddr_d;
      cwdata_q  <= cwdata_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.req_ready_o    = ready_q;
  assign bus.csr_re_o       = re_q;
  // A reset arriving during the write cycle must kill the strobe immediately
  assign bus.csr_we_o       = we_q && !rst_i;
  assign bus.csr_addr_o     = caddr_q;
  assign bus.csr_wdata_o    = cwdata_q;
  assign bus.resp_valid_o   = rvalid_q;
  assign bus.resp_rdata_o   = rdata_q;
  assign bus.resp_illegal_o = illegal_q;

endmodule

// File: tb/tb_muntjac_csr_access_ctrl.sv
// Self-checking bench for muntjac_csr_access_ctrl: directed cases plus random requests
// against a rule-level model of CSR legality, latency and read-modify-write results.
module tb_muntjac_csr_access_ctrl;
  localparam int unsigned XLEN = 64;
`ifdef MUNTJAC_CSR_PRIV_CHECK_EN
  localparam bit PRIV_EN = 1'b1;
`else
  localparam bit PRIV_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic mem_init;
  int   vectors = 0;
  int   miscompares = 0;

  logic [63:0] mem     [4096];
  logic [63:0] ref_mem [4096];

  always #5 clk_i = ~clk_i;

  muntjac_csr_access_ctrl_if #(.XLEN(XLEN)) bus ();
  muntjac_csr_access_ctrl #(.XLEN(XLEN)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));

  function automatic logic [63:0] init_val(input int i);
    return {32'(i) * 32'h9E37_79B1, 32'(i) ^ 32'h5A5A_0F0F};
  endfunction

  // CSR storage: combinational read, write on the strobe
  assign bus.csr_rdata_i = mem[bus.csr_addr_o];
  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
    end else if (bus.csr_we_o) begin
      mem[bus.csr_addr_o] <= bus.csr_wdata_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},   64'(bus.req_ready_o), 64'd1);
    chk({tag, "_rvalid"},  64'(bus.resp_valid_o), 64'd0);
    chk({tag, "_illegal"}, 64'(bus.resp_illegal_o), 64'd0);
    chk({tag, "_rdata"},   bus.resp_rdata_o, 64'd0);
    chk({tag, "_re"},      64'(bus.csr_re_o), 64'd0);
    chk({tag, "_we"},      64'(bus.csr_we_o), 64'd0);
    chk({tag, "_caddr"},   64'(bus.csr_addr_o), 64'd0);
    chk({tag, "_cwdata"},  bus.csr_wdata_o, 64'd0);
  endtask

  // One full request/response; caller is at #1 after a rising edge with the DUT idle
  task automatic run_req(input logic [1:0] op, input logic [11:0] addr,
                         input logic [63:0] wdata, input logic [1:0] priv, input int stall);
    logic        intent, illegal, seen;
    logic [63:0] old, nv, wd_seen, rd_first, il_first;
    int          lat, re_cnt, we_cnt, cyc;
    intent  = (op == 2'd1) || (op >= 2'd2 && wdata != 64'd0);
    illegal = (intent && addr[11:10] == 2'b11) || (PRIV_EN && priv < addr[9:8]);
    old     = ref_mem[addr];
    case (op)
      2'd1:    nv = wdata;
      2'd2:    nv = old | wdata;
      2'd3:    nv = old & ~wdata;
      default: nv = old;
    endcase
    lat = illegal ? 1 : (intent ? 3 : 2);
    re_cnt = 0; we_cnt = 0; wd_seen = '0; seen = 1'b0;

    chk("ready_idle", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_priv_i  = priv;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'($urandom);
    bus.req_addr_i  = 12'($urandom);
    bus.req_wdata_i = {$urandom, $urandom};
    bus.req_priv_i  = 2'($urandom);
    cyc = 1;
    while (!seen && cyc <= 8) begin
      if (bus.csr_re_o) begin
        re_cnt++;
        chk("re_addr", 64'(bus.csr_addr_o), 64'(addr));
      end
      if (bus.csr_we_o) begin
        we_cnt++;
        wd_seen = bus.csr_wdata_o;
        chk("we_addr", 64'(bus.csr_addr_o), 64'(addr));
      end
      if (bus.resp_valid_o) seen = 1'b1;
      else begin
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    chk("resp_seen", 64'(seen), 64'd1);
    chk("latency",   64'(cyc), 64'(lat));
    chk("re_pulses", 64'(re_cnt), illegal ? 64'd0 : 64'd1);
    chk("we_pulses", 64'(we_cnt), (!illegal && intent) ? 64'd1 : 64'd0);
    if (!illegal && intent) chk("csr_wdata", wd_seen, nv);
    chk("resp_rdata",   bus.resp_rdata_o, illegal ? 64'd0 : old);
    chk("resp_illegal", 64'(bus.resp_illegal_o), 64'(illegal));
    chk("ready_busy",   64'(bus.req_ready_o), 64'd0);
    rd_first = bus.resp_rdata_o;
    il_first = 64'(bus.resp_illegal_o);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk_i); #1;
      chk("stall_valid",   64'(bus.resp_valid_o), 64'd1);
      chk("stall_rdata",   bus.resp_rdata_o, rd_first);
      chk("stall_illegal", 64'(bus.resp_illegal_o), il_first);
      chk("stall_ready",   64'(bus.req_ready_o), 64'd0);
      chk("stall_strobes", 64'({bus.csr_re_o, bus.csr_we_o}), 64'd0);
    end
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.resp_ready_i = 1'b0;
    chk("post_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("post_ready", 64'(bus.req_ready_o), 64'd1);
    if (!illegal && intent) ref_mem[addr] = nv;
    chk("mem", mem[addr], ref_mem[addr]);
  endtask

  initial begin
    logic [11:0] a;
    logic [63:0] w;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = 2'd0;
    bus.req_addr_i   = 12'd0;
    bus.req_wdata_i  = 64'd0;
    bus.req_priv_i   = 2'd3;
    bus.resp_ready_i = 1'b0;
    rst_i    = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    rst_i    = 1'b0;
    mem_init = 1'b0;
    @(posedge clk_i); #1;

    // Directed: seed 0x300 with 0xA, read it, SET 0x5 over it
    run_req(2'd1, 12'h300, 64'hA, 2'd3, 0);
    run_req(2'd0, 12'h300, 64'h0, 2'd3, 0);
    run_req(2'd2, 12'h300, 64'h5, 2'd3, 0);
    chk("set_result", mem[12'h300], 64'hF);
    // Read-only space: WRITE faults, CLEAR with zero operand is a legal read
    run_req(2'd1, 12'hC00, 64'h1234, 2'd3, 0);
    run_req(2'd3, 12'hC00, 64'h0, 2'd3, 0);
    // U-mode access to an M-level CSR
    run_req(2'd0, 12'h300, 64'h0, 2'd0, 0);
    // Response backpressure for 5 cycles
    run_req(2'd3, 12'h300, 64'h1, 2'd3, 5);

    // Reset asserted while the controller is in its write cycle
    a = 12'h340;
    w = ~ref_mem[a];
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'd2;
    bus.req_addr_i  = a;
    bus.req_wdata_i = w;
    bus.req_priv_i  = 2'd3;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rmw_we_before_rst", 64'(bus.csr_we_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_we_suppressed", 64'(bus.csr_we_o), 64'd0);
    @(posedge clk_i); #1;
    chk_reset_outputs("midrst");
    rst_i = 1'b0;
    chk("midrst_mem", mem[a], ref_mem[a]);
    @(posedge clk_i); #1;
    chk_reset_outputs("after_midrst");

    // Random requests
    for (int n = 0; n < 150; n++) begin
      a = 12'($urandom);
      if ($urandom_range(0, 3) == 0) a[11:10] = 2'b11;
      w = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      run_req(2'($urandom), a, w, 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
